eth_axis_frame_gen: RTL and testbench

- AXI-stream Ethernet test-frame source in the logic clock domain.
- Drives the tx_axis input of the 10G MAC/PHY FIFO wrapper: the transmitting end of the stream the MAC consumes.
- Builds frames from configured addresses, ethertype and length, with a per-frame sequence number and a deterministic payload, so a far-end checker can verify order and content.
- Handles frame count, stop, inter-frame gap and backpressure.

---
 rtl/eth_axis_frame_gen.sv | 237 +++++++++++++++++++++++
 tb/tb_eth_axis_frame_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_axis_frame_gen.sv
// AXI-stream Ethernet test-frame source: header, sequence number, counting payload.
// Optional tuser error injection with `define ETH_AXIS_FRAME_GEN_ERR_INJ_EN.
module eth_axis_frame_gen #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int MAX_LEN    = 9000,
    parameter int MIN_LEN    = 18
) (
    input  logic                  logic_clk,
    input  logic                  logic_rst_n,
    input  logic [47:0]           cfg_dst_mac,
    input  logic [47:0]           cfg_src_mac,
    input  logic [15:0]           cfg_ethertype,
    input  logic [15:0]           cfg_frame_len,
    input  logic [31:0]           cfg_frame_count,
    input  logic [7:0]            cfg_gap_cycles,
`ifdef ETH_AXIS_FRAME_GEN_ERR_INJ_EN
    input  logic [15:0]           cfg_err_interval,
`endif
    input  logic                  start,
    input  logic                  stop,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           frames_sent
);

    typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

    state_t state_q, state_d;
    logic [47:0] dst_q, dst_d, src_q, src_d;
    logic [15:0] eth_q, eth_d, len_q, len_d;
    logic [31:0] cnt_q, cnt_d, seq_q, seq_d, frames_q, frames_d;
    logic [7:0]  gap_q, gap_d, gcnt_q, gcnt_d;
    logic [12:0] beat_q, beat_d;
    logic        pend_q, pend_d, busy_q, busy_d, done_q, done_d;
    logic        valid_q, valid_d, last_q, last_d, user_q, user_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [KEEP_WIDTH-1:0] keep_q, keep_d;
    logic [15:0] base, n_idx;
    logic        fire;
`ifdef ETH_AXIS_FRAME_GEN_ERR_INJ_EN
    logic [15:0] errint_q, errint_d;
`endif

    function automatic logic [15:0] clamp_len(input logic [15:0] l);
        if (l < 16'(MIN_LEN)) return 16'(MIN_LEN);
        if (l > 16'(MAX_LEN)) return 16'(MAX_LEN);
        return l;
    endfunction

    // Header bytes 0..17 sit MSB-first in one vector; payload byte n is n[7:0].
    function automatic logic [7:0] frame_byte(
        input logic [15:0]  n,
        input logic [143:0] hdr
    );
        logic [143:0] t;
        t = hdr << {n[4:0], 3'b000};
        if (n < 16'd18) return t[143:136];
        return n[7:0];
    endfunction

    assign fire = valid_q & m_axis_tready;

    always_comb begin
        state_d  = state_q;
        dst_d    = dst_q;
        src_d    = src_q;
        eth_d    = eth_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        gcnt_d   = gcnt_q;
        beat_d   = beat_q;
        seq_d    = seq_q;
        frames_d = frames_q;
        pend_d   = pend_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
`ifdef ETH_AXIS_FRAME_GEN_ERR_INJ_EN
        errint_d = errint_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    dst_d    = cfg_dst_mac;
                    src_d    = cfg_src_mac;
                    eth_d    = cfg_ethertype;
                    len_d    = clamp_len(cfg_frame_len);
                    cnt_d    = cfg_frame_count;
                    gap_d    = cfg_gap_cycles;
`ifdef ETH_AXIS_FRAME_GEN_ERR_INJ_EN
                    errint_d = cfg_err_interval;
`endif
                    state_d  = FRAME;
                    busy_d   = 1'b1;
                    valid_d  = 1'b1;
                    beat_d   = '0;
                    seq_d    = '0;
                    frames_d = '0;
                    pend_d   = 1'b0;
                end
            end
            FRAME: begin
                if (stop) pend_d = 1'b1;
                if (fire) begin
                    if (last_q) begin
                        frames_d = frames_q + 32'd1;
                        seq_d    = seq_q + 32'd1;
                        beat_d   = '0;
                        if ((cnt_q != 0 && frames_d == cnt_q) || pend_q || stop) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            valid_d = 1'b0;
                            pend_d  = 1'b0;
                        end else if (gap_q != 0) begin
                            state_d = GAP;
                            gcnt_d  = gap_q;
                            valid_d = 1'b0;
                        end
                    end else begin
                        beat_d = beat_q + 13'd1;
                    end
                end
            end
            GAP: begin
                if (stop || pend_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pend_d  = 1'b0;
                end else if (gcnt_q == 8'd1) begin
                    state_d = FRAME;
                    valid_d = 1'b1;
                end else begin
                    gcnt_d = gcnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next beat's contents follow from the next beat index, so they stay put during stalls.
    always_comb begin
        data_d = '0;
        keep_d = '0;
        last_d = 1'b0;
        user_d = 1'b0;
        n_idx  = '0;
        base   = {beat_d, 3'b000};
        if (valid_d) begin
            for (int i = 0; i < KEEP_WIDTH; i++) begin
                n_idx = base + 16'(i);
                if (n_idx < len_d) begin
                    keep_d[i]       = 1'b1;
                    data_d[8*i +: 8] = frame_byte(n_idx, {dst_d, src_d, eth_d, seq_d});
                end
            end
            last_d = (base + 16'd8) >= len_d;
`ifdef ETH_AXIS_FRAME_GEN_ERR_INJ_EN
            user_d = last_d && (errint_d != 16'd0) &&
                     ((seq_d % {16'd0, errint_d}) == {16'd0, errint_d - 16'd1});
`endif
        end
    end

    always_ff @(posedge logic_clk or negedge logic_rst_n) begin
        if (!logic_rst_n) begin
            state_q  <= IDLE;
            dst_q    <= '0;
            src_q    <= '0;
            eth_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            gcnt_q   <= '0;
            beat_q   <= '0;
            seq_q    <= '0;
            frames_q <= '0;
            pend_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            user_q   <= 1'b0;
            data_q   <= '0;
            keep_q   <= '0;
`ifdef ETH_AXIS_FRAME_GEN_ERR_INJ_EN
            errint_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            dst_q    <= dst_d;
            src_q    <= src_d;
            eth_q    <= eth_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            gcnt_q   <= gcnt_d;
            beat_q   <= beat_d;
            seq_q    <= seq_d;
            frames_q <= frames_d;
            pend_q   <= pend_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            user_q   <= user_d;
            data_q   <= data_d;
            keep_q   <= keep_d;
`ifdef ETH_AXIS_FRAME_GEN_ERR_INJ_EN
            errint_q <= errint_d;
`endif
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tkeep  = keep_q;
    assign m_axis_tvalid = valid_q;
    assign m_axis_tlast  = last_q;
`ifdef ETH_AXIS_FRAME_GEN_ERR_INJ_EN
    assign m_axis_tuser  = user_q;
`else
    assign m_axis_tuser  = 1'b0;
`endif
    assign busy          = busy_q;
    assign done          = done_q;
    assign frames_sent   = frames_q;

endmodule

// File: tb/tb_eth_axis_frame_gen.sv
// Directed bench for eth_axis_frame_gen: framing, clamping, gaps, stop, reset.
// Define ETH_AXIS_FRAME_GEN_ERR_INJ_EN to also exercise tuser injection.
module tb_eth_axis_frame_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] dst = 48'h0011_2233_4455;
    logic [47:0] src = 48'h6677_8899_AABB;
    logic [15:0] eth = 16'h88B5;
    logic [15:0] flen = 16'd64;
    logic [31:0] fcount = 32'd1;
    logic [7:0]  gap = 8'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        tready = 1'b0;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid, tlast, tuser, busy, done;
    logic [31:0] frames_sent;
`ifdef ETH_AXIS_FRAME_GEN_ERR_INJ_EN
    logic [15:0] err_int = 16'd0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] hdr [14];

    always #5 clk = ~clk;

    eth_axis_frame_gen dut (
        .logic_clk       (clk),
        .logic_rst_n     (rst_n),
        .cfg_dst_mac     (dst),
        .cfg_src_mac     (src),
        .cfg_ethertype   (eth),
        .cfg_frame_len   (flen),
        .cfg_frame_count (fcount),
        .cfg_gap_cycles  (gap),
`ifdef ETH_AXIS_FRAME_GEN_ERR_INJ_EN
        .cfg_err_interval(err_int),
`endif
        .start           (start),
        .stop            (stop),
        .m_axis_tdata    (tdata),
        .m_axis_tkeep    (tkeep),
        .m_axis_tvalid   (tvalid),
        .m_axis_tready   (tready),
        .m_axis_tlast    (tlast),
        .m_axis_tuser    (tuser),
        .busy            (busy),
        .done            (done),
        .frames_sent     (frames_sent)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int n, input logic [31:0] seq);
        logic [31:0] s;
        if (n < 14) return hdr[n];
        if (n < 18) begin
            s = seq >> (8 * (17 - n));
            return s[7:0];
        end
        return 8'(n);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_start(input logic [15:0] l, input logic [31:0] c, input logic [7:0] g);
        flen   = l;
        fcount = c;
        gap    = g;
        for (int i = 0; i < 6; i++) begin
            hdr[i]     = 8'(dst >> (8 * (5 - i)));
            hdr[6 + i] = 8'(src >> (8 * (5 - i)));
        end
        hdr[12] = eth[15:8];
        hdr[13] = eth[7:0];
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic recv_frame(
        input  int          len,
        input  logic [31:0] seq,
        input  bit          rnd,
        input  bit          err,
        input  int          stop_beat,
        output int          idle,
        output logic [7:0]  lkeep,
        output logic [63:0] b1
    );
        int beats = (len + 7) / 8;
        int b = 0;
        int bad = 0;
        int cyc = 0;
        bit stopped = 0;
        logic [63:0] ed;
        logic [7:0]  ek;
        idle  = 0;
        lkeep = '0;
        b1    = '0;
        while (b < beats && cyc < 20000) begin
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stop   = 1'b0;
            if (!stopped && b == stop_beat) begin
                stop    = 1'b1;
                stopped = 1;
            end
            if (tvalid) begin
                ed = '0;
                ek = '0;
                for (int i = 0; i < 8; i++) begin
                    if (b * 8 + i < len) begin
                        ek[i]        = 1'b1;
                        ed[8*i +: 8] = exp_byte(b * 8 + i, seq);
                    end
                end
                if (tdata !== ed || tkeep !== ek || tlast !== (b == beats - 1) ||
                    tuser !== (err && b == beats - 1))
                    bad++;
                if (b == 1) b1 = tdata;
                if (b == beats - 1) lkeep = tkeep;
                if (tready) b++;
            end else if (b == 0) begin
                idle++;
            end else begin
                bad++;
            end
            step();
            cyc++;
        end
        stop = 1'b0;
        check($sformatf("beats seq%0d", seq), 64'(b), 64'(beats));
        check($sformatf("data seq%0d", seq), 64'(bad), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int          idle;
        int          vcnt;
        logic [7:0]  lk;
        logic [63:0] b1;

        #12;
        check("rst tvalid", 64'(tvalid), 64'd0);
        check("rst tdata", tdata, 64'd0);
        check("rst tkeep", 64'(tkeep), 64'd0);
        check("rst flags", 64'({tlast, tuser, busy, done}), 64'd0);
        check("rst frames", 64'(frames_sent), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // L=64, single frame
        run_start(16'd64, 32'd1, 8'd0);
        check("t1 busy", 64'(busy), 64'd1);
        check("t1 beat0", tdata, 64'h7766_5544_3322_1100);
        recv_frame(64, 32'd0, 0, 0, -1, idle, lk, b1);
        check("t1 beat1", b1, 64'h0000_B588_BBAA_9988);
        check("t1 lkeep", 64'(lk), 64'hFF);
        check("t1 done", 64'(done), 64'd1);
        check("t1 busy end", 64'(busy), 64'd0);
        check("t1 frames", 64'(frames_sent), 64'd1);
        step();
        check("t1 done pulse", 64'(done), 64'd0);

        // L=61, three frames, gap 4
        run_start(16'd61, 32'd3, 8'd4);
        for (int k = 0; k < 3; k++) begin
            recv_frame(61, 32'(k), 0, 0, -1, idle, lk, b1);
            check($sformatf("t2 idle%0d", k), 64'(idle), (k == 0) ? 64'd0 : 64'd4);
            check($sformatf("t2 lkeep%0d", k), 64'(lk), 64'h1F);
        end
        check("t2 frames", 64'(frames_sent), 64'd3);
        check("t2 done", 64'(done), 64'd1);
        step();

        // clamping
        run_start(16'd10, 32'd1, 8'd0);
        recv_frame(18, 32'd0, 0, 0, -1, idle, lk, b1);
        check("t3 short lkeep", 64'(lk), 64'h03);
        check("t3 short frames", 64'(frames_sent), 64'd1);
        step();
        run_start(16'd20000, 32'd1, 8'd0);
        recv_frame(9000, 32'd0, 0, 0, -1, idle, lk, b1);
        check("t3 long lkeep", 64'(lk), 64'hFF);
        check("t3 long done", 64'(done), 64'd1);
        step();

        // continuous, random ready, stop during frame 5
        run_start(16'd40, 32'd0, 8'd2);
        for (int k = 0; k < 6; k++)
            recv_frame(40, 32'(k), 1, 0, (k == 5) ? 2 : -1, idle, lk, b1);
        check("t4 done", 64'(done), 64'd1);
        check("t4 frames", 64'(frames_sent), 64'd6);
        check("t4 busy", 64'(busy), 64'd0);
        tready = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (tvalid) vcnt++;
            step();
        end
        check("t4 no frame6", 64'(vcnt), 64'd0);

        // start and stop together
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("t5 busy", 64'(busy), 64'd0);
        step();
        check("t5 tvalid", 64'(tvalid), 64'd0);

        // reset during beat 3
        run_start(16'd64, 32'd0, 8'd0);
        repeat (3) step();
        check("t5 beat3", tdata, 64'h1F1E_1D1C_1B1A_1918);
        rst_n = 1'b0;
        #1;
        check("t5 rst tvalid", 64'(tvalid), 64'd0);
        check("t5 rst tlast", 64'(tlast), 64'd0);
        check("t5 rst tdata", tdata, 64'd0);
        check("t5 rst busy", 64'(busy), 64'd0);
        check("t5 rst frames", 64'(frames_sent), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

`ifdef ETH_AXIS_FRAME_GEN_ERR_INJ_EN
        err_int = 16'd3;
        run_start(16'd24, 32'd6, 8'd1);
        for (int k = 0; k < 6; k++)
            recv_frame(24, 32'(k), 0, (k % 3 == 2), -1, idle, lk, b1);
        check("t6 frames", 64'(frames_sent), 64'd6);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
